// File: rtl/sysmon_temp_poller_pkg.sv
// Shared types and constants for the SYSMON temperature poller and its consumers.
package sysmon_temp_poller_pkg;

  // Width of the temperature code, shared with the warm-boot block's temp_in/temp_thresh.
  localparam int TEMP_W = 10;

  localparam logic [7:0] SYSMON_TEMP_ADDR     = 8'h00;
  localparam logic [7:0] SYSMON_MAX_TEMP_ADDR = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_ACC  = 2'd3
  } poll_state_t;

endpackage

// File: rtl/temp_avg_acc.sv
// Power-of-two boxcar averager: sums 2^AVG_LOG2 samples, then emits the truncated mean
// with a one-cycle strobe.
module temp_avg_acc
  import sysmon_temp_poller_pkg::*;
#(
  parameter int AVG_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TEMP_W-1:0] sample,
  input  logic              sample_valid,
  output logic [TEMP_W-1:0] avg,
  output logic              avg_valid,
  output logic [TEMP_W-1:0] avg_next,
  output logic              avg_load
);

  localparam int ACC_W = TEMP_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] count;

  // acc holds at most (2^AVG_LOG2 - 1) full-scale samples, so sum never wraps.
  assign sum      = acc + ACC_W'(sample);
  assign avg_next = sum[ACC_W-1:AVG_LOG2];
  assign avg_load = sample_valid && (count == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      count     <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= avg_load;
      if (avg_load) begin
        avg   <= avg_next;
        acc   <= '0;
        count <= '0;
      end else if (sample_valid) begin
        acc   <= sum;
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sysmon_temp_poller.sv
// Polls the SYSMON temperature register over DRP, averages the readings and keeps
// a peak-hold value plus a sticky read-timeout flag.
module sysmon_temp_poller
  import sysmon_temp_poller_pkg::*;
#(
  parameter int         POLL_CYCLES    = 100000,
  parameter int         AVG_LOG2       = 3,
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [7:0] TEMP_ADDR      = SYSMON_TEMP_ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              drp_den,
  output logic [7:0]        drp_daddr,
  output logic              drp_dwe,
  output logic [15:0]       drp_di,
  input  logic [15:0]       drp_do,
  input  logic              drp_drdy,
  input  logic              clear,
  output logic [TEMP_W-1:0] temp_out,
  output logic              temp_valid,
  output logic [TEMP_W-1:0] temp_max,
  output logic              timeout_err
);

  localparam int POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  poll_state_t       state;
  logic [POLL_W-1:0] poll_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [TEMP_W-1:0] sample;
  logic              den_q;
  logic              timeout_evt;
  logic [TEMP_W-1:0] avg;
  logic [TEMP_W-1:0] avg_next;
  logic              avg_valid;
  logic              avg_load;
  logic              unused_lsbs;

  // DRP handshake: drp_den is a single-cycle request; the read completes on the first
  // drp_drdy seen while in WAIT (drdy in any other state is ignored). No new request
  // is issued until that read completes or times out, so at most one is outstanding.
  assign drp_den     = den_q;
  assign drp_daddr   = TEMP_ADDR;
  assign drp_dwe     = 1'b0;
  assign drp_di      = 16'h0000;
  assign unused_lsbs = ^drp_do[5:0];

  assign timeout_evt = (state == ST_WAIT) && !drp_drdy && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      poll_cnt <= '0;
      tmo_cnt  <= '0;
      sample   <= '0;
      den_q    <= 1'b0;
    end else begin
      den_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (poll_cnt == POLL_LAST) begin
            poll_cnt <= '0;
            den_q    <= 1'b1;
            state    <= ST_REQ;
          end else begin
            poll_cnt <= poll_cnt + POLL_W'(1);
          end
        end
        ST_REQ: state <= ST_WAIT;
        ST_WAIT: begin
          if (drp_drdy) begin
            sample  <= drp_do[15:6];
            tmo_cnt <= '0;
            state   <= ST_ACC;
          end else if (timeout_evt) begin
            tmo_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ST_ACC:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  temp_avg_acc #(
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample      (sample),
    .sample_valid(state == ST_ACC),
    .avg         (avg),
    .avg_valid   (avg_valid),
    .avg_next    (avg_next),
    .avg_load    (avg_load)
  );

  assign temp_out   = avg;
  assign temp_valid = avg_valid;

  // A fresh average beats a simultaneous clear; a timeout beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp_max    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (timeout_evt) begin
        timeout_err <= 1'b1;
      end else if (clear) begin
        timeout_err <= 1'b0;
      end
      if (avg_load && (clear || (avg_next > temp_max))) begin
        temp_max <= avg_next;
      end else if (clear) begin
        temp_max <= '0;
      end
    end
  end

endmodule

// File: doc/sysmon_temp_poller.md
Name: sysmon_temp_poller

Overview:
Periodically reads the on-die temperature from the SYSMONE DRP port using the den/drdy handshake. Averages a power-of-two number of samples and presents a 10-bit temperature code with a one-cycle valid strobe. The output drives temp_in of the over-temperature warm-boot block. The block also keeps a peak-hold value and a sticky DRP-timeout error for software readback.

Parameters:
POLL_CYCLES, 100000, clk cycles between DRP read requests; legal range 1 and above.
AVG_LOG2, 3, log2 of the samples averaged per output; legal range 0..6.
TIMEOUT_CYCLES, 255, maximum cycles to wait for drp_drdy before aborting a read.
TEMP_ADDR, 8'h00, DRP address of the SYSMON temperature status register.

Ports:
clk  in  1  system clock; SYSMON DCLK is the same clock
rst_n  in  1  asynchronous active-low reset
drp_den  out  1  DRP enable; one-cycle pulse per read
drp_daddr  out  8  DRP address
drp_dwe  out  1  DRP write enable; always 0
drp_di  out  16  DRP write data; always 16'h0000
drp_do  in  16  DRP read data
drp_drdy  in  1  DRP data ready
clear  in  1  synchronous clear of temp_max and timeout_err
temp_out  out  10  averaged temperature code; drp_do[15:6] scale
temp_valid  out  1  one-cycle strobe when temp_out updates
temp_max  out  10  highest temp_out value since reset or clear
timeout_err  out  1  sticky flag: a DRP read timed out

Behaviour:
- Reset (async assert, sync release):
  - drp_den=0, drp_daddr=TEMP_ADDR, dwe=0, di=0.
  - temp_out=0, temp_valid=0, temp_max=0, timeout_err=0.
  - Accumulator, sample count and timers = 0; FSM goes to IDLE.
  - temp_out=0 is below any sane threshold, so reset never triggers a reboot downstream.
- FSM states: IDLE, REQ, WAIT, ACC.
  - IDLE: poll timer counts up from 0. At POLL_CYCLES-1 the timer resets and the FSM moves to REQ. First request leaves IDLE after POLL_CYCLES cycles from reset release.
  - REQ: drp_den=1 for exactly this one cycle with daddr=TEMP_ADDR. Go to WAIT. drp_drdy seen in REQ is ignored.
  - WAIT: on drp_drdy, capture drp_do[15:6] and go to ACC. Otherwise increment the timeout counter.
  - WAIT timeout: when the counter reaches TIMEOUT_CYCLES with no drdy, set timeout_err, discard the read, and return to IDLE. Accumulator and sample count are unchanged.
  - ACC: acc += sample; count += 1.
    - If count reaches 2^AVG_LOG2: temp_out <= (acc+sample) >> AVG_LOG2 (truncating), temp_valid=1 next cycle, then acc and count clear.
    - Return to IDLE in either case.
- Width rules: accumulator is 10+AVG_LOG2 bits and cannot overflow. With AVG_LOG2=0 every sample passes straight through.
- Latency: temp_valid rises 2 cycles after the drdy of the final sample (capture, then ACC). temp_out holds its value between strobes.
- temp_max: updated on the same cycle as temp_out when the new value is greater than temp_max.
- clear:
  - clear=1 sets temp_max to 0 and timeout_err to 0.
  - clear on the same cycle as a temp_out update: temp_max takes the new value.
  - clear on the same cycle as a timeout: timeout_err ends at 1 (set wins).
- drp_drdy in IDLE or ACC (spurious) is ignored and changes no state.
- Only one DRP transaction is ever outstanding. den is never reasserted before drdy or timeout.
- rst_n asserted mid-WAIT: abort immediately. After release a late drdy arrives while in IDLE and is ignored.

Decomposition:
- Shared package:
  - FSM state enum.
  - SYSMON address constants: TEMP_ADDR=8'h00, MAX_TEMP=8'h20.
  - Constant TEMP_W=10, shared with the warm-boot block's temp_in/temp_thresh width.
- One natural sub-module: temp_avg_acc, holding the accumulator, sample counter and divide-by-shift. Inputs are sample plus sample_valid; outputs are avg plus avg_valid. The top keeps the FSM, the timers and the DRP pins.

Test Plan:
- Reset release, POLL_CYCLES=10, AVG_LOG2=2, DRP model answers drp_do=16'hB700 one cycle after den -> first den at cycle 10, one den every ~13 cycles; after 4 reads temp_out=10'h2DC, temp_valid high exactly 1 cycle, temp_max=10'h2DC.
- Samples with drp_do[15:6]=100, 101, 102, 104, AVG_LOG2=2 -> temp_out=101 (407>>2 truncates).
- DRP model never drives drdy, TIMEOUT_CYCLES=5 -> timeout_err=1 six cycles after den, FSM returns to IDLE, next den one poll period later, accumulator count unchanged.
- Averages 300, then 250; clear pulsed; then 280 -> temp_max is 300, stays 300, goes to 0 on clear, then 280; clear asserted on the timeout cycle leaves timeout_err=1.
- rst_n pulsed low while in WAIT, model returns drdy 3 cycles later -> all outputs 0, late drdy ignored, no temp_valid; normal polling resumes.
- Spurious drdy pulse in IDLE with drp_do=16'hFFC0 -> no accumulation, temp_out unchanged, den timing unaffected.
